// File: rtl/cdic_pkg.sv
// rtl/cdic_pkg.sv - shared types and constants for the CDIC sector parser
package cdic_pkg;

  localparam int SLOT_ADDR_WIDTH = 11;
  localparam logic [10:0] SECTOR_WORDS = 11'd1188;
  localparam logic [10:0] DATA_WORDS   = 11'd1176;
  localparam logic [10:0] HDR_IDX      = 11'd6;
  localparam logic [10:0] SUBHDR_IDX   = 11'd8;
  localparam logic [10:0] SUBCODE_IDX  = DATA_WORDS;

  // 00 FF*10 00 on disc, packed little-endian into 16-bit words
  localparam logic [15:0] SYNC_WORDS [0:5] = '{
    16'hFF00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00FF
  };

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_HEADER, ST_SUBHDR, ST_BODY, ST_SUBCODE, ST_FLUSH, ST_DONE
  } state_e;

  typedef struct packed {
    logic [23:0] msf;
    logic [7:0]  mode;
    logic [7:0]  file;
    logic [7:0]  channel;
    logic [7:0]  submode;
    logic [7:0]  coding;
  } hdr_t;

endpackage

// File: rtl/cdic_sync_checker.sv
// rtl/cdic_sync_checker.sv - sticky compare of words 0-5 against the sync pattern
module cdic_sync_checker
  import cdic_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        word_valid,
  input  logic [10:0] word_idx,
  input  logic [15:0] word_data,
  output logic        sync_mismatch
);

  logic sticky_q, sticky_d;
  logic hit;

  always_comb begin
    hit = 1'b0;
    if (word_valid && (word_idx < 11'd6)) begin
      hit = (word_data != SYNC_WORDS[word_idx[2:0]]);
    end
    sticky_d = (clear ? 1'b0 : sticky_q) | hit;
  end

  always_ff @(posedge clk) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  // Next-state view so a sector ending on the same clock still sees its last word
  assign sync_mismatch = sticky_d;

endmodule

// File: rtl/cdic_sector_parser.sv
// rtl/cdic_sector_parser.sv - sector word stream to CDIC buffer slots; CDIC_FILE_FILTER_EN adds file filtering
module cdic_sector_parser
  import cdic_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_sector_delivered,
  input  logic        abort,
  input  logic [1:0]  slot_sel,
  input  logic [7:0]  filter_file,
  output logic [12:0] buf_addr,
  output logic [15:0] buf_data,
  output logic        buf_we,
  output logic [23:0] hdr_msf,
  output logic [7:0]  hdr_mode,
  output logic [7:0]  sub_file,
  output logic [7:0]  sub_channel,
  output logic [7:0]  sub_submode,
  output logic [7:0]  sub_coding,
  output logic        sector_done,
  output logic [1:0]  sector_slot,
  output logic        sync_err,
  output logic        len_err,
  output logic        sector_skipped
);

`ifdef CDIC_FILE_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  state_e state_q, state_d;
  logic [SLOT_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]  slot_q, slot_d, done_slot_q, done_slot_d;
  logic        len_flag_q, len_flag_d, skip_q, skip_d;
  hdr_t        shadow_q, shadow_d, hdr_q, hdr_d;
  logic        we_q, we_d, done_q, done_d;
  logic [12:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        sync_err_q, sync_err_d, len_err_q, len_err_d, skipped_q, skipped_d;
  logic        word_ok, count, start, sync_mismatch;

  cdic_sync_checker u_sync (
    .clk           (clk),
    .reset         (reset),
    .clear         (start),
    .word_valid    (count),
    .word_idx      (cnt_q),
    .word_data     (in_data),
    .sync_mismatch (sync_mismatch)
  );

  always_comb begin
    word_ok     = in_valid && !abort && (state_q != ST_DONE);
    count       = word_ok && (cnt_q < SECTOR_WORDS);
    start       = word_ok && (state_q == ST_IDLE);
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = start ? slot_sel : slot_q;
    len_flag_d  = len_flag_q;
    skip_d      = skip_q;
    shadow_d    = shadow_q;
    hdr_d       = hdr_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    done_d      = 1'b0;
    done_slot_d = done_slot_q;
    sync_err_d  = sync_err_q;
    len_err_d   = len_err_q;
    skipped_d   = skipped_q;

    if (count) begin
      cnt_d  = cnt_q + 11'd1;
      we_d   = !skip_q;
      addr_d = {slot_d, cnt_q};
      data_d = in_data;
      case (cnt_q)
        HDR_IDX:              shadow_d.msf[23:8] = {in_data[7:0], in_data[15:8]};
        HDR_IDX + 11'd1:      begin
                                shadow_d.msf[7:0] = in_data[7:0];
                                shadow_d.mode     = in_data[15:8];
                              end
        SUBHDR_IDX:           begin
                                shadow_d.file    = in_data[7:0];
                                shadow_d.channel = in_data[15:8];
                                if (FILTER_EN && (shadow_q.mode == 8'd2) && (in_data[7:0] != filter_file))
                                  skip_d = 1'b1;
                              end
        SUBHDR_IDX + 11'd1:   begin
                                shadow_d.submode = in_data[7:0];
                                shadow_d.coding  = in_data[15:8];
                              end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE:    if (word_ok) state_d = ST_SYNC;
      ST_SYNC:    if (count && cnt_q == HDR_IDX - 11'd1) state_d = ST_HEADER;
      ST_HEADER:  if (count && cnt_q == SUBHDR_IDX - 11'd1) state_d = ST_SUBHDR;
      ST_SUBHDR:  if (count && cnt_q == SUBHDR_IDX + 11'd1) state_d = ST_BODY;
      ST_BODY:    if (count && cnt_q == SUBCODE_IDX - 11'd1) state_d = ST_SUBCODE;
      ST_DONE:    state_d = ST_IDLE;
      default: ;
    endcase

    // Excess words are swallowed until the cache signals end of sector
    if (word_ok && !count) begin
      len_flag_d = 1'b1;
      state_d    = ST_FLUSH;
    end

    if (abort) begin
      state_d = ST_IDLE;
    end else if (in_sector_delivered && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_d     = ST_DONE;
      done_d      = 1'b1;
      done_slot_d = slot_q;
      sync_err_d  = sync_mismatch;
      len_err_d   = len_flag_d | (cnt_d != SECTOR_WORDS);
      skipped_d   = skip_d;
      hdr_d       = shadow_d;
    end

    if (state_d == ST_IDLE) begin
      cnt_d      = '0;
      len_flag_d = 1'b0;
      skip_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      len_flag_q  <= 1'b0;
      skip_q      <= 1'b0;
      shadow_q    <= '0;
      hdr_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      done_slot_q <= '0;
      sync_err_q  <= 1'b0;
      len_err_q   <= 1'b0;
      skipped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      len_flag_q  <= len_flag_d;
      skip_q      <= skip_d;
      shadow_q    <= shadow_d;
      hdr_q       <= hdr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      done_slot_q <= done_slot_d;
      sync_err_q  <= sync_err_d;
      len_err_q   <= len_err_d;
      skipped_q   <= skipped_d;
    end
  end

  assign buf_addr       = addr_q;
  assign buf_data       = data_q;
  assign buf_we         = we_q;
  assign hdr_msf        = hdr_q.msf;
  assign hdr_mode       = hdr_q.mode;
  assign sub_file       = hdr_q.file;
  assign sub_channel    = hdr_q.channel;
  assign sub_submode    = hdr_q.submode;
  assign sub_coding     = hdr_q.coding;
  assign sector_done    = done_q;
  assign sector_slot    = done_slot_q;
  assign sync_err       = sync_err_q;
  assign len_err        = len_err_q;
  assign sector_skipped = skipped_q;

endmodule

// File: tb/tb_cdic_sector_parser.sv
// tb/tb_cdic_sector_parser.sv - randomized directed bench for cdic_sector_parser
module tb_cdic_sector_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid, in_sector_delivered, abort;
  logic [1:0]  slot_sel;
  logic [7:0]  filter_file;
  logic [12:0] buf_addr;
  logic [15:0] buf_data;
  logic        buf_we;
  logic [23:0] hdr_msf;
  logic [7:0]  hdr_mode, sub_file, sub_channel, sub_submode, sub_coding;
  logic        sector_done, sync_err, len_err, sector_skipped;
  logic [1:0]  sector_slot;

  cdic_sector_parser dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_sector_delivered(in_sector_delivered), .abort(abort), .slot_sel(slot_sel),
    .filter_file(filter_file), .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
    .hdr_msf(hdr_msf), .hdr_mode(hdr_mode), .sub_file(sub_file), .sub_channel(sub_channel),
    .sub_submode(sub_submode), .sub_coding(sub_coding), .sector_done(sector_done),
    .sector_slot(sector_slot), .sync_err(sync_err), .len_err(len_err),
    .sector_skipped(sector_skipped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [28:0] wr_q[$];
  logic [7:0]  bytes [0:2379];
  logic [1:0]  d_slot;
  logic        d_sync, d_len, d_skip;
  logic [63:0] d_hdr;

  always @(negedge clk) begin
    if (buf_we) wr_q.push_back({buf_addr, buf_data});
    if (sector_done) begin
      done_cnt++;
      d_slot = sector_slot;
      d_sync = sync_err;
      d_len  = len_err;
      d_skip = sector_skipped;
      d_hdr  = {hdr_msf, hdr_mode, sub_file, sub_channel, sub_submode, sub_coding};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [23:0] msf, input logic [7:0] mode, input logic [7:0] file);
    for (int i = 0; i < 2380; i++) bytes[i] = 8'($urandom);
    bytes[0] = 8'h00;
    for (int i = 1; i <= 10; i++) bytes[i] = 8'hFF;
    bytes[11] = 8'h00;
    bytes[12] = msf[23:16]; bytes[13] = msf[15:8]; bytes[14] = msf[7:0];
    bytes[15] = mode; bytes[16] = file;
  endtask

  task automatic send(input logic [1:0] slot, input int n, input bit same_cycle);
    wr_q.delete();
    slot_sel = slot;
    for (int w = 0; w < n; w++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = {bytes[2*w+1], bytes[2*w]};
      if (w == n - 1 && same_cycle) in_sector_delivered = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sector_delivered = 1'b0;
      in_data  = 16'($urandom);
      slot_sel = 2'($urandom);
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic deliver();
    @(posedge clk); #1;
    in_sector_delivered = 1'b1;
    @(posedge clk); #1;
    in_sector_delivered = 1'b0;
  endtask

  task automatic expect_sector(input string tag, input logic [1:0] slot, input int n, input int prev);
    int nw;
    bit exp_sync, exp_skip;
    nw = (n < 1188) ? n : 1188;
    exp_skip = 1'b0;
`ifdef CDIC_FILE_FILTER_EN
    if (bytes[15] == 8'd2 && bytes[16] != filter_file) begin
      exp_skip = 1'b1;
      if (nw > 9) nw = 9;
    end
`endif
    exp_sync = 1'b0;
    for (int b = 0; b < 12; b++)
      if (bytes[b] != ((b == 0 || b == 11) ? 8'h00 : 8'hFF)) exp_sync = 1'b1;
    for (int c = 0; c < 50 && done_cnt == prev; c++) @(posedge clk);
    repeat (5) @(posedge clk);
    check({tag, "_done_count"}, 64'(done_cnt), 64'(prev + 1));
    check({tag, "_wr_count"}, 64'(wr_q.size()), 64'(nw));
    for (int i = 0; i < nw && i < wr_q.size(); i++)
      check({tag, "_wr"}, 64'(wr_q[i]), 64'({slot, 11'(i), bytes[2*i+1], bytes[2*i]}));
    check({tag, "_slot"}, 64'(d_slot), 64'(slot));
    check({tag, "_sync_err"}, 64'(d_sync), 64'(exp_sync));
    check({tag, "_len_err"}, 64'(d_len), 64'(n != 1188));
    check({tag, "_skipped"}, 64'(d_skip), 64'(exp_skip));
    check({tag, "_header"}, d_hdr,
          {bytes[12], bytes[13], bytes[14], bytes[15], bytes[16], bytes[17], bytes[18], bytes[19]});
  endtask

  initial begin
    logic [1:0] rs;
    int prev;
    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_sector_delivered = 1'b0;
    abort = 1'b0; slot_sel = 2'd0; filter_file = 8'd1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_buf_we", 64'(buf_we), 64'd0);
    check("rst_buf_addr", 64'(buf_addr), 64'd0);
    check("rst_done", 64'(sector_done), 64'd0);
    check("rst_hdr", 64'({hdr_msf, hdr_mode, sub_file}), 64'd0);
    check("rst_errs", 64'({sync_err, len_err, sector_skipped, sector_slot}), 64'd0);

    filter_file = 8'd1;
    build(24'h000216, 8'd2, 8'd1);
    prev = done_cnt; send(2'd2, 1188, 1'b0); deliver();
    expect_sector("clean", 2'd2, 1188, prev);

    rs = 2'($urandom);
    build(24'($urandom), 8'd2, 8'd1);
    bytes[6] = 8'hFE;
    prev = done_cnt; send(rs, 1188, 1'b1);
    expect_sector("sync", rs, 1188, prev);

    rs = 2'($urandom);
    build(24'($urandom), 8'd1, 8'($urandom));
    prev = done_cnt; send(rs, 1000, 1'b0); deliver();
    expect_sector("short", rs, 1000, prev);

    rs = 2'($urandom);
    build(24'($urandom), 8'd2, 8'd1);
    prev = done_cnt; send(rs, 1190, 1'b0); deliver();
    expect_sector("long", rs, 1190, prev);

    build(24'($urandom), 8'd2, 8'd1);
    prev = done_cnt; send(2'd3, 500, 1'b0);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    deliver();
    repeat (10) @(posedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(prev));
    check("abort_wr_count", 64'(wr_q.size()), 64'd500);

    build(24'($urandom), 8'd2, 8'd1);
    prev = done_cnt; send(2'd1, 1188, 1'b0); deliver();
    expect_sector("after_abort", 2'd1, 1188, prev);

    filter_file = 8'd3;
    build(24'h000217, 8'd2, 8'd1);
    prev = done_cnt; send(2'd0, 1188, 1'b0); deliver();
    expect_sector("filter", 2'd0, 1188, prev);

    build(24'($urandom), 8'd2, 8'd3);
    prev = done_cnt; send(2'd2, 20, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_hdr", 64'({hdr_msf, hdr_mode}), 64'd0);
    check("midrst_we", 64'(buf_we), 64'd0);
    deliver();
    repeat (5) @(posedge clk);
    check("midrst_no_done", 64'(done_cnt), 64'(prev));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdic_sector_parser.md
Name: cdic_sector_parser

Overview:
- Downstream consumer of the HPS CD sector cache word stream (cd_data/cd_data_valid/sector_delivered).
- Checks the 12-byte sync pattern and latches header/subheader (MSF, mode, file, channel, submode, coding).
- Writes each sector's 16-bit words into one of four CDIC buffer RAM slots and reports completion status to the CDIC register block.

Parameters:
- SECTOR_WORDS, 1188, words per delivered sector: 1176 data + 12 subchannel.
- DATA_WORDS, 1176, words of raw 0x930-byte sector data.
- SLOT_ADDR_WIDTH, 11, word address width within one buffer slot (2048 words).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_data  in  16  sector word; low byte is the earlier byte on disc
- in_valid  in  1  word strobe; at least 3 idle clocks between strobes
- in_sector_delivered  in  1  pulse, end of sector from cache
- abort  in  1  pulse, discard current sector (seek/stop)
- slot_sel  in  2  target buffer slot, sampled at first word of sector
- filter_file  in  8  file number filter (used only with feature)
- buf_addr  out  13  {slot, word_index}
- buf_data  out  16  word to buffer RAM
- buf_we  out  1  buffer write strobe
- hdr_msf  out  24  {min, sec, frame}, BCD as on disc
- hdr_mode  out  8  header mode byte
- sub_file, sub_channel, sub_submode, sub_coding  out  8 each  subheader bytes
- sector_done  out  1  pulse, sector complete
- sector_slot  out  2  slot of completed sector
- sync_err  out  1  valid with sector_done; sync mismatch
- len_err  out  1  valid with sector_done; word count != SECTOR_WORDS
- sector_skipped  out  1  valid with sector_done; filtered out

Behaviour:
- Reset: all outputs 0, state IDLE, word counter 0, latched slot 0.
- States: IDLE, SYNC (words 0-5), HEADER (6-7), SUBHDR (8-9), BODY (10-1175), SUBCODE (1176-1187), FLUSH, DONE.
- IDLE -> SYNC on first in_valid; latch slot_sel and clear error flags.
- Every accepted word (while counter < SECTOR_WORDS) produces buf_we = 1 exactly one clock after in_valid, with buf_addr = {slot, counter}, buf_data = in_data. Counter is 11-bit and increments per accepted word.
- Expected sync words: 0xFF00, 0xFFFF x4, 0x00FF. Any mismatch sets sync_err sticky for the sector; writes continue.
- Word 6 -> hdr_msf[23:8] = {byte12, byte13}. Word 7 -> hdr_msf[7:0] = byte14, hdr_mode = byte15.
- Word 8 -> sub_file, sub_channel. Word 9 -> sub_submode, sub_coding.
- Header/subheader outputs are updated only at sector_done, from shadow registers, so they stay stable for the whole next sector.
- Words beyond SECTOR_WORDS: not written; set len_err; remain in FLUSH until in_sector_delivered.
- in_sector_delivered in any non-IDLE state -> DONE for one clock. sector_done = 1, sector_slot = latched slot, len_err |= (counter != SECTOR_WORDS). Then IDLE.
- in_sector_delivered in IDLE is ignored.
- in_sector_delivered in the same clock as a final in_valid: the word is accepted first and counted, then DONE.
- abort: highest priority. -> IDLE next clock, no sector_done. A buf_we already in its pipeline cycle still completes; counter cleared.
- reset mid-sector: same as abort, plus all outputs cleared.
- Latency: in_valid -> buf_we = 1 clk. Final word -> sector_done >= 1 clk (gated by in_sector_delivered).

Optional Feature:
- Macro CDIC_FILE_FILTER_EN.
- Enabled: after word 8, if hdr_mode == 2 and sub_file != filter_file, suppress buf_we for the rest of the sector. Words 0-8 are already written. sector_done still pulses, with sector_skipped = 1.
- Disabled: filter_file ignored, sector_skipped tied 0, all words written.

Decomposition:
- Package cdic_pkg: state enum, SYNC_WORDS constant array, word-index constants (HDR_IDX = 6, SUBHDR_IDX = 8, SUBCODE_IDX = 1176), SECTOR_WORDS.
- One sub-module, cdic_sync_checker: word index + data in, mismatch flag out, combinational with sticky register.

Test Plan:
- Clean mode-2 sector, 1188 words, slot_sel = 2, header MSF 00:02:16 mode 2, file 1 -> 1188 writes at addrs 0x1000-0x14A3; sector_done with hdr_msf = 0x000216, sync_err = 0, len_err = 0.
- Sync word 3 = 0xFFFE -> sync_err = 1 at sector_done; all 1188 words still written.
- Short sector, delivered after 1000 words -> sector_done, len_err = 1, 1000 writes.
- 1190 words -> only 1188 writes; len_err = 1 at delivery.
- abort after word 500, then a new clean sector on slot 1 -> no sector_done for the first; second completes with writes at 0x0800+.
- CDIC_FILE_FILTER_EN, filter_file = 3, sector file = 1 -> 9 writes; sector_done with sector_skipped = 1.
